// File: rtl/traffic_phase_scheduler_if.sv
// Request/preemption inputs and lamp/status outputs of the traffic phase scheduler.
// The scheduler takes the slave side; the request/lamp-driver side takes the master side.
interface traffic_phase_scheduler_if;
  logic [3:0] req;
  logic       preempt_valid;
  logic [1:0] preempt_dir;
  logic [3:0] lamp_red;
  logic [3:0] lamp_yellow;
  logic [3:0] lamp_green;
  logic [1:0] cur_dir;
  logic [1:0] phase;
  logic [3:0] pending;

  modport master (
    output req,
    output preempt_valid,
    output preempt_dir,
    input  lamp_red,
    input  lamp_yellow,
    input  lamp_green,
    input  cur_dir,
    input  phase,
    input  pending
  );

  modport slave (
    input  req,
    input  preempt_valid,
    input  preempt_dir,
    output lamp_red,
    output lamp_yellow,
    output lamp_green,
    output cur_dir,
    output phase,
    output pending
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection sequencer: GREEN -> YELLOW -> ALLRED with latched requests,
// round-robin service, min/max green timing and emergency preemption.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV    = 10_000_000,
  parameter int unsigned GREEN_MIN   = 30,
  parameter int unsigned GREEN_MAX   = 300,
  parameter int unsigned YELLOW_TIME = 30,
  parameter int unsigned ALLRED_TIME = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  traffic_phase_scheduler_if.slave    bus
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TimerW = $clog2(GREEN_MAX + 1);

  typedef enum logic [1:0] {
    StAllRed = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [1:0]        cur_dir_q, cur_dir_d;
  logic [3:0]        pending_q, pending_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        lamp_red_q, lamp_red_d;
  logic [3:0]        lamp_yellow_q, lamp_yellow_d;
  logic [3:0]        lamp_green_q, lamp_green_d;

  logic              tick;
  logic [31:0]       t;
  logic [3:0]        cur_oh;
  logic [3:0]        others;
  logic              rr_found;
  logic [1:0]        rr_dir;
  logic [1:0]        rr_idx;
  logic              phase_entry;
  logic [3:0]        set_mask;
  logic [3:0]        clr_mask;
  logic [3:0]        next_oh;

  // Round-robin pick: first pending approach after the last served one, wrapping to itself.
  always_comb begin
    rr_found = 1'b0;
    rr_dir   = cur_dir_q;
    rr_idx   = cur_dir_q;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = cur_dir_q + 2'(i);
      if (!rr_found && pending_q[rr_idx]) begin
        rr_found = 1'b1;
        rr_dir   = rr_idx;
      end
    end
  end

  always_comb begin
    tick      = (presc_q == PrescW'(TICK_DIV - 1));
    t         = 32'(timer_q) + 32'd1;
    cur_oh    = 4'b0001 << cur_dir_q;
    others    = pending_q & ~cur_oh;
    phase_d   = phase_q;
    cur_dir_d = cur_dir_q;

    case (phase_q)
      StGreen: begin
        // A preempt for the current approach pins green; one for another forces yellow now.
        if (bus.preempt_valid) begin
          if (bus.preempt_dir != cur_dir_q) begin
            phase_d = StYellow;
          end
        end else if (tick && (others != 4'b0000) && (t >= GREEN_MIN) &&
                     (!bus.req[cur_dir_q] || (t >= GREEN_MAX))) begin
          phase_d = StYellow;
        end
      end
      StYellow: begin
        if (tick && (t >= YELLOW_TIME)) begin
          phase_d = StAllRed;
        end
      end
      StAllRed: begin
        if (tick && (t >= ALLRED_TIME)) begin
          if (bus.preempt_valid) begin
            phase_d   = StGreen;
            cur_dir_d = bus.preempt_dir;
          end else if (rr_found) begin
            phase_d   = StGreen;
            cur_dir_d = rr_dir;
          end
        end
      end
      default: begin
        phase_d = StAllRed;
      end
    endcase
  end

  // Timing base restarts on every phase entry so an N-tick phase is exactly N*TICK_DIV cycles.
  always_comb begin
    phase_entry = (phase_d != phase_q);
    if (phase_entry || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PrescW'(1);
    end
    if (phase_entry) begin
      timer_d = '0;
    end else if (tick && (timer_q != TimerW'(GREEN_MAX))) begin
      timer_d = timer_q + TimerW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Clear on green entry takes priority over a simultaneous request.
  always_comb begin
    next_oh  = 4'b0001 << cur_dir_d;
    set_mask = bus.req & ~((phase_q == StGreen) ? cur_oh : 4'b0000);
    clr_mask = ((phase_d == StGreen) && (phase_q != StGreen)) ? next_oh : 4'b0000;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_comb begin
    lamp_red_d    = 4'hF;
    lamp_yellow_d = 4'h0;
    lamp_green_d  = 4'h0;
    case (phase_d)
      StGreen: begin
        lamp_green_d = next_oh;
        lamp_red_d   = ~next_oh;
      end
      StYellow: begin
        lamp_yellow_d = next_oh;
        lamp_red_d    = ~next_oh;
      end
      default: begin
        lamp_red_d = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= StAllRed;
      cur_dir_q     <= 2'd3;
      pending_q     <= 4'h0;
      presc_q       <= '0;
      timer_q       <= '0;
      lamp_red_q    <= 4'hF;
      lamp_yellow_q <= 4'h0;
      lamp_green_q  <= 4'h0;
    end else begin
      phase_q       <= phase_d;
      cur_dir_q     <= cur_dir_d;
      pending_q     <= pending_d;
      presc_q       <= presc_d;
      timer_q       <= timer_d;
      lamp_red_q    <= lamp_red_d;
      lamp_yellow_q <= lamp_yellow_d;
      lamp_green_q  <= lamp_green_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.cur_dir     = cur_dir_q;
  assign bus.pending     = pending_q;
  assign bus.lamp_red    = lamp_red_q;
  assign bus.lamp_yellow = lamp_yellow_q;
  assign bus.lamp_green  = lamp_green_q;

  // Exactly one lamp lit per approach.
  a_one_lamp: assert property (@(posedge clk) disable iff (reset)
    ((lamp_red_q | lamp_yellow_q | lamp_green_q) == 4'hF) &&
    ((lamp_red_q & lamp_yellow_q) == 4'h0) &&
    ((lamp_red_q & lamp_green_q) == 4'h0) &&
    ((lamp_yellow_q & lamp_green_q) == 4'h0));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expected phase transitions and their
// durations are queued as stimulus is applied and checked as the DUT changes phase.
module tb_traffic_phase_scheduler;

  localparam logic [1:0] PhAllRed = 2'b00;
  localparam logic [1:0] PhGreen  = 2'b01;
  localparam logic [1:0] PhYellow = 2'b10;

  typedef struct {
    logic [1:0] phase;
    logic [1:0] dir;
    int         len;
  } ev_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   last_cyc;
  logic [3:0] last_key;
  ev_t  exp_q[$];

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .TICK_DIV    (4),
    .GREEN_MIN   (3),
    .GREEN_MAX   (6),
    .YELLOW_TIME (2),
    .ALLRED_TIME (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ph, input logic [1:0] d, input int len);
    ev_t e;
    e.phase = ph;
    e.dir   = d;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_for(input logic [1:0] ph, input logic [1:0] d, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (bus.phase == ph) && (bus.cur_dir == d);
    end
    chk("wait_phase", {31'b0, hit}, 32'd1);
  endtask

  // Called on the first negedge of a fresh green for 'from'; ends on first negedge of green 'to'.
  task automatic hop(input logic [1:0] from, input logic [1:0] to, input int green_len);
    bus.req = 4'b0001 << to;
    push(PhYellow, from, green_len);
    push(PhAllRed, from, 8);
    push(PhGreen, to, 4);
    @(negedge clk);
    bus.req = 4'b0000;
    wait_for(PhGreen, to, 60);
  endtask

  // Transition monitor: every phase/direction change must match the head of the queue.
  initial begin
    ev_t e;
    logic [3:0] key;
    cyc      = 0;
    last_cyc = 0;
    last_key = 4'h0;
    forever begin
      @(negedge clk);
      cyc++;
      key = {bus.phase, bus.cur_dir};
      if (reset) begin
        last_key = key;
        last_cyc = cyc;
      end else if (key != last_key) begin
        if (exp_q.size() == 0) begin
          chk("spurious_transition", {28'b0, key}, {28'b0, last_key});
        end else begin
          e = exp_q.pop_front();
          chk("ev_phase", {30'b0, bus.phase}, {30'b0, e.phase});
          chk("ev_dir", {30'b0, bus.cur_dir}, {30'b0, e.dir});
          if (e.len >= 0) chk("ev_len", cyc - last_cyc, e.len);
        end
        last_key = key;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    n_cmp             = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus.req           = 4'b0000;
    bus.preempt_valid = 1'b0;
    bus.preempt_dir   = 2'd0;

    repeat (100) begin
      @(negedge clk);
      chk("rst_red", {28'b0, bus.lamp_red}, 32'hF);
      chk("rst_phase", {30'b0, bus.phase}, 32'h0);
      chk("rst_pending", {28'b0, bus.pending}, 32'h0);
    end
    chk("rst_green", {28'b0, bus.lamp_green}, 32'h0);
    chk("rst_yellow", {28'b0, bus.lamp_yellow}, 32'h0);
    chk("rst_dir", {30'b0, bus.cur_dir}, 32'd3);
    reset = 1'b0;

    // Single request from idle all-red.
    repeat (10) @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = 4'b0000;
    chk("req_latch", {28'b0, bus.pending}, 32'b0100);
    push(PhGreen, 2'd2, -1);
    wait_for(PhGreen, 2'd2, 6);
    chk("g2_pending_clr", {28'b0, bus.pending}, 32'h0);
    chk("g2_lamp_green", {28'b0, bus.lamp_green}, 32'b0100);
    chk("g2_lamp_red", {28'b0, bus.lamp_red}, 32'b1011);

    // Round-robin order from dir 2 with requests on 1 and 3.
    bus.req = 4'b1010;
    push(PhYellow, 2'd2, 12);
    push(PhAllRed, 2'd2, 8);
    push(PhGreen, 2'd3, 4);
    push(PhYellow, 2'd3, 12);
    push(PhAllRed, 2'd3, 8);
    push(PhGreen, 2'd1, 4);
    @(negedge clk);
    bus.req = 4'b0000;
    wait_for(PhGreen, 2'd3, 40);
    chk("rr_pending", {28'b0, bus.pending}, 32'b0010);
    wait_for(PhGreen, 2'd1, 40);

    // Minimum-green exit with the served approach idle.
    hop(2'd1, 2'd0, 12);
    hop(2'd0, 2'd1, 12);
    chk("g1_lamp_green", {28'b0, bus.lamp_green}, 32'b0010);
    hop(2'd1, 2'd0, 12);

    // Held demand on dir 0 extends green to the maximum.
    bus.req = 4'b1001;
    push(PhYellow, 2'd0, 24);
    push(PhAllRed, 2'd0, 8);
    push(PhGreen, 2'd3, 4);
    @(negedge clk);
    bus.req = 4'b0001;
    wait_for(PhYellow, 2'd0, 40);
    bus.req = 4'b0000;
    wait_for(PhGreen, 2'd3, 30);

    // Rest in green with nobody else waiting.
    hop(2'd3, 2'd0, 12);
    bus.req = 4'b0001;
    repeat (210) @(negedge clk);
    chk("rest_phase", {30'b0, bus.phase}, {30'b0, PhGreen});
    chk("rest_dir", {30'b0, bus.cur_dir}, 32'd0);
    chk("rest_lamp", {28'b0, bus.lamp_green}, 32'b0001);

    bus.req = 4'b0010;
    push(PhYellow, 2'd0, -1);
    push(PhAllRed, 2'd0, 8);
    push(PhGreen, 2'd1, 4);
    @(negedge clk);
    bus.req = 4'b0000;
    wait_for(PhGreen, 2'd1, 30);
    hop(2'd1, 2'd0, 12);

    // Preemption at timer zero: yellow on the very next edge.
    bus.preempt_valid = 1'b1;
    bus.preempt_dir   = 2'd2;
    push(PhYellow, 2'd0, 1);
    push(PhAllRed, 2'd0, 8);
    push(PhGreen, 2'd2, 4);
    wait_for(PhGreen, 2'd2, 30);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (40) @(negedge clk);
    chk("pre_hold_phase", {30'b0, bus.phase}, {30'b0, PhGreen});
    chk("pre_hold_dir", {30'b0, bus.cur_dir}, 32'd2);
    chk("pre_hold_pending", {28'b0, bus.pending}, 32'b0010);
    chk("pre_hold_red", {28'b0, bus.lamp_red}, 32'b1011);

    push(PhYellow, 2'd2, -1);
    bus.preempt_valid = 1'b0;
    wait_for(PhYellow, 2'd2, 10);
    @(negedge clk);
    chk("y2_pending", {28'b0, bus.pending}, 32'b0010);
    chk("y2_lamp_yellow", {28'b0, bus.lamp_yellow}, 32'b0100);

    // Asynchronous reset mid-yellow.
    #2 reset = 1'b1;
    #1;
    chk("async_phase", {30'b0, bus.phase}, 32'h0);
    chk("async_red", {28'b0, bus.lamp_red}, 32'hF);
    chk("async_yellow", {28'b0, bus.lamp_yellow}, 32'h0);
    chk("async_pending", {28'b0, bus.pending}, 32'h0);
    chk("async_dir", {30'b0, bus.cur_dir}, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_phase", {30'b0, bus.phase}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
